// File: rtl/morse_symbol_sequencer.sv
// Morse symbol sequencer: packs dot/dash pulses into symbols, times letter and word
// gaps in prescaled Morse units and hands tokens downstream over valid/ready.
module morse_symbol_sequencer #(
  parameter int TICK_DIV   = 1000000,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int MAX_ELEM   = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                key_in,
  input  logic                dot_in,
  input  logic                dash_in,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic [MAX_ELEM-1:0] sym_bits,
  output logic [2:0]          sym_len,
  output logic                sym_space,
  output logic                sym_err,
  output logic                drop_pulse
);

  localparam int UW = $clog2(TICK_DIV);
  localparam int GW = $clog2(WORD_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_EMIT      = 3'd2,
    S_WAIT_WORD = 3'd3,
    S_SPACE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [UW-1:0]       unit_cnt_q, unit_cnt_d;
  logic [GW-1:0]       gap_units_q, gap_units_d;
  logic [MAX_ELEM-1:0] acc_bits_q, acc_bits_d;
  logic [2:0]          acc_len_q, acc_len_d;
  logic                err_flag_q, err_flag_d;
  logic                sym_valid_q, sym_valid_d;
  logic [MAX_ELEM-1:0] sym_bits_q, sym_bits_d;
  logic [2:0]          sym_len_q, sym_len_d;
  logic                sym_space_q, sym_space_d;
  logic                sym_err_q, sym_err_d;
  logic                drop_pulse_q, drop_pulse_d;

  logic any_pulse, both_pulse, elem, accept;
  logic unit_wrap, gap_inc, letter_hit, word_hit, acc_full;
  logic start_sym, store_elem, overflow, drop;

  // A simultaneous dot+dash is never a valid element, but it still counts as activity.
  assign any_pulse  = dot_in | dash_in;
  assign both_pulse = dot_in & dash_in;
  assign elem       = any_pulse & ~both_pulse;
  assign accept     = sym_valid_q & sym_ready;
  assign unit_wrap  = (unit_cnt_q == UW'(TICK_DIV - 1));
  assign gap_inc    = ~key_in & ~any_pulse & unit_wrap & (gap_units_q != GW'(WORD_GAP));
  assign letter_hit = gap_inc & (gap_units_q == GW'(LETTER_GAP - 1));
  assign word_hit   = gap_inc & (gap_units_q == GW'(WORD_GAP - 1));
  assign acc_full   = (acc_len_q == 3'(MAX_ELEM));

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      unit_cnt_q   <= '0;
      gap_units_q  <= '0;
      acc_bits_q   <= '0;
      acc_len_q    <= 3'd0;
      err_flag_q   <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_bits_q   <= '0;
      sym_len_q    <= 3'd0;
      sym_space_q  <= 1'b0;
      sym_err_q    <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_cnt_q   <= unit_cnt_d;
      gap_units_q  <= gap_units_d;
      acc_bits_q   <= acc_bits_d;
      acc_len_q    <= acc_len_d;
      err_flag_q   <= err_flag_d;
      sym_valid_q  <= sym_valid_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      sym_space_q  <= sym_space_d;
      sym_err_q    <= sym_err_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  // Unit prescaler and saturating idle-unit counter; any key or pulse activity restarts both.
  always_comb begin
    unit_cnt_d  = unit_cnt_q;
    gap_units_d = gap_units_q;
    if (key_in || any_pulse) begin
      unit_cnt_d  = '0;
      gap_units_d = '0;
    end else if (unit_wrap) begin
      unit_cnt_d = '0;
      if (gap_inc) begin
        gap_units_d = gap_units_q + GW'(1);
      end else begin
        gap_units_d = gap_units_q;
      end
    end else begin
      unit_cnt_d = unit_cnt_q + UW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (elem) state_d = S_COLLECT;
        else      state_d = S_IDLE;
      end
      S_COLLECT: begin
        if (letter_hit) state_d = S_EMIT;
        else            state_d = S_COLLECT;
      end
      S_EMIT: begin
        if (accept && elem) state_d = S_COLLECT;
        else if (accept)    state_d = S_WAIT_WORD;
        else                state_d = S_EMIT;
      end
      S_WAIT_WORD: begin
        // Gap may already be saturated if the letter sat unaccepted for a whole word gap.
        if (elem)                                                state_d = S_COLLECT;
        else if (word_hit || (gap_units_q == GW'(WORD_GAP)))     state_d = S_SPACE;
        else                                                     state_d = S_WAIT_WORD;
      end
      S_SPACE: begin
        if (accept && elem) state_d = S_COLLECT;
        else if (accept)    state_d = S_IDLE;
        else                state_d = S_SPACE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Element accumulation, token loading and drop detection.
  always_comb begin
    start_sym    = elem & (state_d == S_COLLECT) & (state_q != S_COLLECT);
    store_elem   = elem & (state_q == S_COLLECT) & ~acc_full;
    overflow     = elem & (state_q == S_COLLECT) & acc_full;
    drop         = both_pulse | (elem & ((state_q == S_EMIT) || (state_q == S_SPACE)) & ~accept);
    acc_bits_d   = acc_bits_q;
    acc_len_d    = acc_len_q;
    err_flag_d   = err_flag_q;
    sym_valid_d  = sym_valid_q;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    sym_space_d  = sym_space_q;
    sym_err_d    = sym_err_q;
    drop_pulse_d = drop;

    if (start_sym) begin
      acc_bits_d = {{(MAX_ELEM-1){1'b0}}, dash_in};
      acc_len_d  = 3'd1;
      err_flag_d = 1'b0;
    end else if (store_elem) begin
      for (int i = 0; i < MAX_ELEM; i++) begin
        acc_bits_d[i] = (acc_len_q == 3'(i)) ? dash_in : acc_bits_q[i];
      end
      acc_len_d = acc_len_q + 3'd1;
    end else if (overflow) begin
      err_flag_d = 1'b1;
    end else begin
      acc_len_d = acc_len_q;
    end

    if ((state_q == S_COLLECT) && (state_d == S_EMIT)) begin
      sym_valid_d = 1'b1;
      sym_bits_d  = acc_bits_q;
      sym_len_d   = acc_len_q;
      sym_space_d = 1'b0;
      sym_err_d   = err_flag_q;
    end else if ((state_q == S_WAIT_WORD) && (state_d == S_SPACE)) begin
      sym_valid_d = 1'b1;
      sym_bits_d  = '0;
      sym_len_d   = 3'd0;
      sym_space_d = 1'b1;
      sym_err_d   = 1'b0;
    end else if (accept) begin
      sym_valid_d = 1'b0;
      sym_bits_d  = '0;
      sym_len_d   = 3'd0;
      sym_space_d = 1'b0;
      sym_err_d   = 1'b0;
    end else begin
      sym_valid_d = sym_valid_q;
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_bits   = sym_bits_q;
  assign sym_len    = sym_len_q;
  assign sym_space  = sym_space_q;
  assign sym_err    = sym_err_q;
  assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for morse_symbol_sequencer: a per-step vector table plus hand-written
// sequences for reset, letter timing, backpressure, key hold and back-to-back letters.
module tb_morse_symbol_sequencer;

  localparam int TD = 4;
  localparam int LG = 3;
  localparam int WG = 7;
  localparam int ME = 5;

  logic          clk = 1'b0;
  logic          reset_n, key_in, dot_in, dash_in, sym_ready;
  logic          sym_valid, sym_space, sym_err, drop_pulse;
  logic [ME-1:0] sym_bits;
  logic [2:0]    sym_len;

  int checks   = 0;
  int failures = 0;

  morse_symbol_sequencer #(.TICK_DIV(TD), .LETTER_GAP(LG), .WORD_GAP(WG), .MAX_ELEM(ME)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .dot_in(dot_in), .dash_in(dash_in),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_bits(sym_bits), .sym_len(sym_len),
    .sym_space(sym_space), .sym_err(sym_err), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dot, dash, key, ready;
    int         idle;
    logic       ev;
    logic [4:0] eb;
    logic [2:0] el;
    logic       es, ee, ed;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [4:0] eb,
                           input logic [2:0] el, input logic es, input logic ee, input logic ed);
    check({tag, ".valid"}, 32'(sym_valid),  32'(ev));
    check({tag, ".bits"},  32'(sym_bits),   32'(eb));
    check({tag, ".len"},   32'(sym_len),    32'(el));
    check({tag, ".space"}, 32'(sym_space),  32'(es));
    check({tag, ".err"},   32'(sym_err),    32'(ee));
    check({tag, ".drop"},  32'(drop_pulse), 32'(ed));
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    key_in    = 1'b0;
    dot_in    = 1'b0;
    dash_in   = 1'b0;
    sym_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Steps until sym_valid is seen; n is the step count, or 0 if the bound expires.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (sym_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, cnt2, first;

    // dot dash key ready idle | valid bits len space err drop
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 11, 1'b1, 5'b11111, 3'd5, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 14, 1'b1, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 40, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};

    // Reset state, then overflow / simultaneous-pulse / space sequence from the table.
    do_reset();
    check_out("reset", 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      dot_in    = tbl[i].dot;
      dash_in   = tbl[i].dash;
      key_in    = tbl[i].key;
      sym_ready = tbl[i].ready;
      step();
      dot_in  = 1'b0;
      dash_in = 1'b0;
      for (int k = 0; k < tbl[i].idle; k++) step();
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].el, tbl[i].es, tbl[i].ee, tbl[i].ed);
    end

    // Reset in the middle of a two-element symbol discards it.
    do_reset();
    dot_in = 1'b1; step(); dot_in = 1'b0;
    dash_in = 1'b1; step(); dash_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check_out("in_reset", 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sym_valid === 1'b1) cnt++;
    end
    check("rst_no_token", 32'(cnt), 32'd0);
    dot_in = 1'b1; step(); dot_in = 1'b0;
    wait_valid(30, n);
    check("rst_fresh_lat", 32'(n), 32'd12);
    check_out("rst_fresh", 1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0);

    // Letter A with exact letter and word gap timing, and a single space token.
    do_reset();
    dot_in = 1'b1; step(); dot_in = 1'b0;
    key_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    key_in = 1'b0;
    dash_in = 1'b1; step(); dash_in = 1'b0;
    wait_valid(30, n);
    check("A_lat", 32'(n), 32'd12);
    check_out("A", 1'b1, 5'b00010, 3'd2, 1'b0, 1'b0, 1'b0);
    cnt = 0; cnt2 = 0; first = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (sym_valid === 1'b1 && sym_space === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
      if (sym_valid === 1'b1 && sym_space !== 1'b1) cnt2++;
    end
    check("A_space_lat", 32'(first), 32'd16);
    check("A_space_count", 32'(cnt), 32'd1);
    check("A_no_extra_sym", 32'(cnt2), 32'd0);

    // Key held far longer than a word gap never times out.
    do_reset();
    dot_in = 1'b1; step(); dot_in = 1'b0;
    key_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sym_valid === 1'b1) cnt++;
    end
    check("keyhold_no_token", 32'(cnt), 32'd0);
    key_in = 1'b0;
    wait_valid(30, n);
    check("keyhold_lat", 32'(n), 32'd12);
    check_out("keyhold", 1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0);

    // Backpressure: token held, dropped dot flagged, space follows right after release.
    do_reset();
    dot_in = 1'b1; step(); dot_in = 1'b0;
    wait_valid(30, n);
    check("bp_lat", 32'(n), 32'd12);
    sym_ready = 1'b0;
    for (int c = 0; c < 36; c++) begin
      dot_in = (c == 2);
      step();
      dot_in = 1'b0;
      check_out($sformatf("bp_stall%0d", c), 1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, (c == 2));
    end
    sym_ready = 1'b1;
    step();
    check_out("bp_accept", 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("bp_space", 1'b1, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("bp_space_accept", 32'(sym_valid), 32'd0);

    // Back-to-back: dash in the accept cycle starts the next letter, no space between.
    do_reset();
    dot_in = 1'b1; step(); dot_in = 1'b0;
    wait_valid(30, n);
    check("b2b_first_lat", 32'(n), 32'd12);
    dash_in = 1'b1; step(); dash_in = 1'b0;
    check_out("b2b_accept", 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    wait_valid(40, n);
    check("b2b_second_lat", 32'(n), 32'd12);
    check_out("b2b_second", 1'b1, 5'b00001, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
